// File: rtl/io_responder.sv
// rtl/io_responder.sv - I/O instruction responder: TX FIFO toward host, RX fetch FSM, core stall.
module io_responder #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          out_en,
  input  logic [DW-1:0] out_data,
  input  logic          in_en,
  output logic [DW-1:0] in_data,
  output logic          in_done,
  output logic          stall,
  output logic          tx_valid,
  output logic [DW-1:0] tx_data,
  input  logic          tx_ready,
  input  logic          rx_valid,
  input  logic [DW-1:0] rx_data,
  output logic          rx_ready,
  output logic [AW:0]   tx_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} rx_state_t;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;
  rx_state_t     state;
  rx_state_t     state_next;

  // Full blocks the push even when a pop happens in the same cycle.
  assign full     = (tx_count == CNT_FULL);
  assign push     = out_en & ~full;
  assign tx_valid = (tx_count != '0);
  assign pop      = tx_valid & tx_ready;
  assign tx_data  = tx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= out_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      in_data <= '0;
    end else begin
      state <= state_next;
      if (state == S_WAIT && rx_valid) begin
        in_data <= rx_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_en) state_next = S_WAIT;
      S_WAIT:  if (rx_valid) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign rx_ready = (state == S_WAIT);
  assign in_done  = (state == S_DONE);
  assign stall    = (out_en & full) | (in_en & (state != S_DONE));

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Device-side responder for the core's Input/Output instructions; sits between the core datapath and the external host/display interface.
- Output instructions push the register value into a small TX FIFO, which drains to the host over a valid/ready handshake.
- Input instructions fetch one word from the host over a valid/ready handshake.
- Asserts a stall back to the core while an I/O instruction cannot complete.

Parameters:
- DW, 16, data word width (matches the 16-bit register file)
- DEPTH, 4, TX FIFO entries (power of two, >= 2)
- AW, 2, log2(DEPTH), pointer width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high; one clock; no other reset
- out_en  input  1  core Output instruction active; held high while stall=1
- out_data  input  DW  register value to output; held stable with out_en
- in_en  input  1  core Input instruction active; held high while stall=1
- in_data  output  DW  word returned to the core for write-back (registered)
- in_done  output  1  one-cycle pulse: in_data valid, Input instruction completes
- stall  output  1  core must freeze the PC and hold the current instruction
- tx_valid  output  1  TX FIFO head valid toward host
- tx_data  output  DW  TX FIFO head word
- tx_ready  input  1  host accepts tx_data
- rx_valid  input  1  host offers rx_data
- rx_data  input  DW  host word for Input
- rx_ready  output  1  block will accept rx_data this cycle
- tx_count  output  AW+1  current TX FIFO occupancy 0..DEPTH

Behaviour:
- Reset (async, immediate):
  - wr_ptr=rd_ptr=0, tx_count=0, tx_valid=0, tx_data=0.
  - rx state=IDLE, rx_ready=0, in_data=0, in_done=0.
  - FIFO contents are discarded. An in-flight Input is abandoned; the core is expected to be reset too.
- TX FIFO:
  - push = out_en & (tx_count != DEPTH); writes out_data at wr_ptr, wr_ptr+1 mod DEPTH.
  - pop = tx_valid & tx_ready; rd_ptr+1 mod DEPTH.
  - tx_valid = (tx_count != 0); tx_data = mem[rd_ptr], no extra latency.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full: no push. A pop in that cycle does NOT permit a same-cycle push; the push lands the next cycle.
  - Pointers wrap naturally at DEPTH. tx_count never exceeds DEPTH or underflows.
  - Output instruction latency: 1 cycle when not full (out_en sampled, stall=0, push at edge).
- RX FSM states: IDLE, WAIT, DONE.
  - IDLE: in_en=1 -> WAIT.
  - WAIT: rx_ready=1. rx_valid & rx_ready -> capture rx_data into in_data, go to DONE. Otherwise stay; no timeout.
  - DONE: in_done=1, rx_ready=0, go to IDLE.
  - rx_ready is a registered state decode (high only in WAIT).
  - Minimum Input latency: in_en at cycle 0, in_done at cycle 2 if rx_valid was already high in cycle 1.
  - in_data holds its value until the next capture.
- stall (combinational) = (out_en & tx_count==DEPTH) | (in_en & state!=DONE).
  - Core advances on the cycle stall=0, so exactly one push per Output and one capture per Input.
- Simultaneous out_en and in_en: illegal from the decoder. If it occurs, the two paths operate independently and stall is the OR.
- in_en dropping while in WAIT: not permitted. If it happens, the FSM still completes the capture and pulses in_done, which is ignored.

Test Plan:
- Reset mid-traffic: fill FIFO with 3 words, assert rst for 1 cycle -> tx_count=0, tx_valid=0, state IDLE, in_data=0 immediately, before the next clk edge.
- Output path, tx_ready=1: out_en with 0x1234 then 0xBEEF on consecutive cycles -> stall=0 throughout; tx_data=0x1234 then 0xBEEF; tx_count returns to 0.
- FIFO full, tx_ready=0:
  - Push 0x0001..0x0004 -> tx_count=4.
  - 5th out_en (0x0005) -> stall=1.
  - Raise tx_ready one cycle -> 0x0001 popped. stall drops the following cycle and 0x0005 is pushed.
  - Drain order is 1,2,3,4,5.
- Simultaneous push/pop at count=2 -> count stays 2, order preserved across pointer wrap after 10 words.
- Input path:
  - in_en with rx_valid=0 for 5 cycles -> stall=1, rx_ready=1, in_done=0.
  - Then rx_valid=1, rx_data=0xA5A5 -> next cycle in_done=1, in_data=0xA5A5, stall=0.
- Input fast path: rx_valid held high with 0x00FF, in_en -> in_done exactly 2 cycles after in_en. A second back-to-back Input returns the same 0x00FF with 2-cycle latency.
